exec_sequencer: RTL and testbench
=================================

// Module: exec_sequencer
// PURPOSE
//  Multi-cycle control FSM for the LEGv8 execute/memory datapath. Accepts one
//  32-bit instruction at a time, decodes opcode Instruction[31:21], and drives
//  the Execution stage control inputs (ALUSrc, ALUOp, B/BZ/BNZ, Mem*, RegWrite)
//  over IDLE->DECODE->EXEC->MEM->WB. Sits between fetch and Execution and
//  paces data-memory handshakes.
// PARAMETERS
//  EXEC_LATENCY  1   cycles the ALU result needs to settle after ExecEnable (>=1)
//  MEM_TIMEOUT   16  max cycles waiting for MemReady before abort (>=1)
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  reset        in   1   synchronous, active-high reset
//  InstrValid   in   1   fetch presents a valid instruction
//  InstrReady   out  1   sequencer can accept (high only in IDLE)
//  Instruction  in   32  instruction word; captured on InstrValid&&InstrReady
//  MemReady     in   1   data memory completed current read/write
//  ALUSrc       out  2   00 reg Data2, 01 signExt, 10 imm12 Instr[21:10]
//  ALUOp        out  2   00 add (LD/ST), 01 pass (CBZ/CBNZ), 10 R/I funct
//  B,BZ,BNZ     out  1   branch kind, held EXEC through WB
//  MemRead      out  1   held in MEM until MemReady or timeout
//  MemWrite     out  1   held in MEM until MemReady or timeout
//  MemtoReg     out  1   writeback selects memory data
//  RegWrite     out  1   one-cycle pulse in WB
//  ExecEnable   out  1   one-cycle pulse on EXEC entry
//  PCWrite      out  1   one-cycle pulse at retirement (WB)
//  Busy         out  1   state != IDLE
//  IllegalOp    out  1   one-cycle pulse, unknown opcode
//  Timeout      out  1   one-cycle pulse, MEM aborted
// BEHAVIOUR
//  - Reset: state IDLE; every output 0 except InstrReady=1; counters 0; latched
//    instruction 0. Reset in any state aborts with no RegWrite/PCWrite.
//  - IDLE: on InstrValid&&InstrReady latch Instruction, go DECODE (1 cycle).
//  - DECODE (prefix match on captured word):
//    R ADD 10001011000/SUB 11001011000/AND 10001010000/ORR 10101010000:
//      ALUSrc=00 ALUOp=10 RegWrite in WB
//    I ADDI 1001000100x/SUBI 1101000100x: ALUSrc=10 ALUOp=10 RegWrite in WB
//    LDUR 11111000010: ALUSrc=01 ALUOp=00 MemRead MemtoReg RegWrite
//    STUR 11111000000: ALUSrc=01 ALUOp=00 MemWrite; no RegWrite
//    CBZ 10110100xxx -> BZ; CBNZ 10110101xxx -> BNZ; ALUSrc=00 ALUOp=01
//    B 000101xxxxx -> B; ALUOp=01; no ALU dependence
//    else: IllegalOp pulse, PCWrite pulse, back to IDLE (skip instruction).
//  - EXEC: ExecEnable high first cycle only; remain EXEC_LATENCY cycles total;
//    then MEM if LDUR/STUR, else WB.
//  - MEM: MemRead/MemWrite asserted from entry; cycle counter from 1. Exit on
//    MemReady high (same edge -> WB; Mem* drop next cycle). Counter reaching
//    MEM_TIMEOUT without MemReady: Mem* drop, Timeout pulse, IDLE, no PCWrite
//    (fetch replays). MemReady outside MEM ignored.
//  - WB: exactly one cycle; RegWrite (if decoded) and PCWrite pulse; control
//    outputs return to 0 next cycle; state IDLE.
//  - Latency: ALU op 1+EXEC_LATENCY+1 cycles accept->retire; memory op adds
//    wait cycles. Throughput one instruction in flight; InstrValid while Busy
//    ignored (fetch holds it).
//  - Outputs registered (no combinational path Instruction->controls).
//  - MemRead and MemWrite never high together; B/BZ/BNZ one-hot or zero.
// STRUCTURE
//  - Shared package legv8_pkg: opcode constants/masks, ALUSrc/ALUOp encodings,
//    state enum values.
//  - One sub-module natural: legv8_decode (combinational opcode -> control
//    bundle + legal flag), reused by future pipelined control.
//  - Top: state register, EXEC/MEM counters, output registers.
// TESTING
//  - ADD 0x8B020020 at reset release -> ALUSrc=00 ALUOp=10, ExecEnable 1 cycle,
//    RegWrite+PCWrite pulse 3 cycles after accept (EXEC_LATENCY=1).
//  - LDUR 0xF8408020, MemReady after 4 cycles -> MemRead high 4 cycles, MemtoReg=1,
//    RegWrite+PCWrite in WB, MemRead low after.
//  - STUR, MemReady never -> MemWrite high 16 cycles, Timeout pulse, no PCWrite,
//    InstrReady=1 next cycle.
//  - CBNZ 0xB5000040 -> BNZ=1 held EXEC..WB, RegWrite=0, PCWrite pulse once.
//  - Opcode 0x000 word -> IllegalOp + PCWrite pulse, no ExecEnable, back IDLE.
//  - reset asserted mid-MEM -> next cycle all outputs 0, InstrReady=1, no pulses.

Source files
------------

// File: rtl/legv8_pkg.sv
// ============================================================================
// Module  : legv8_pkg
// Purpose : Opcode patterns, control encodings, and sequencer state values
//           for the LEGv8 execute/memory control.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package legv8_pkg;

    localparam logic [1:0] c_alusrc_reg   = 2'b00;
    localparam logic [1:0] c_alusrc_sext  = 2'b01;
    localparam logic [1:0] c_alusrc_imm12 = 2'b10;

    localparam logic [1:0] c_aluop_add    = 2'b00;
    localparam logic [1:0] c_aluop_pass   = 2'b01;
    localparam logic [1:0] c_aluop_funct  = 2'b10;

    // Opcode values are compared after masking off the don't-care low bits
    localparam logic [10:0] c_mask_full = 11'h7FF;
    localparam logic [10:0] c_mask_i    = 11'h7FE;
    localparam logic [10:0] c_mask_cb   = 11'h7F8;
    localparam logic [10:0] c_mask_b    = 11'h7E0;

    localparam logic [10:0] c_op_add  = 11'h458;
    localparam logic [10:0] c_op_sub  = 11'h658;
    localparam logic [10:0] c_op_and  = 11'h450;
    localparam logic [10:0] c_op_orr  = 11'h550;
    localparam logic [10:0] c_op_addi = 11'h488;
    localparam logic [10:0] c_op_subi = 11'h688;
    localparam logic [10:0] c_op_ldur = 11'h7C2;
    localparam logic [10:0] c_op_stur = 11'h7C0;
    localparam logic [10:0] c_op_cbz  = 11'h5A0;
    localparam logic [10:0] c_op_cbnz = 11'h5A8;
    localparam logic [10:0] c_op_b    = 11'h0A0;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_decode = 3'd1;
    localparam logic [2:0] c_st_exec   = 3'd2;
    localparam logic [2:0] c_st_mem    = 3'd3;
    localparam logic [2:0] c_st_wb     = 3'd4;

    typedef struct packed {
        logic [1:0] alusrc;
        logic [1:0] aluop;
        logic       b;
        logic       bz;
        logic       bnz;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       legal;
    } ctrl_t;

    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] val,
                                      input logic [10:0] mask);
        return (op & mask) == val;
    endfunction

endpackage

`default_nettype wire

// File: rtl/legv8_decode.sv
// ============================================================================
// Module  : legv8_decode
// Purpose : Combinational LEGv8 opcode decoder producing a control bundle
//           and a legal-opcode flag.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module legv8_decode
    import legv8_pkg::*;
(
    input  logic [10:0] opcode,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl = '0;
        if (op_match(opcode, c_op_add, c_mask_full) || op_match(opcode, c_op_sub, c_mask_full) ||
            op_match(opcode, c_op_and, c_mask_full) || op_match(opcode, c_op_orr, c_mask_full)) begin
            ctrl.alusrc    = c_alusrc_reg;
            ctrl.aluop     = c_aluop_funct;
            ctrl.reg_write = 1'b1;
            ctrl.legal     = 1'b1;
        end else if (op_match(opcode, c_op_addi, c_mask_i) || op_match(opcode, c_op_subi, c_mask_i)) begin
            ctrl.alusrc    = c_alusrc_imm12;
            ctrl.aluop     = c_aluop_funct;
            ctrl.reg_write = 1'b1;
            ctrl.legal     = 1'b1;
        end else if (op_match(opcode, c_op_ldur, c_mask_full)) begin
            ctrl.alusrc     = c_alusrc_sext;
            ctrl.aluop      = c_aluop_add;
            ctrl.mem_read   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.legal      = 1'b1;
        end else if (op_match(opcode, c_op_stur, c_mask_full)) begin
            ctrl.alusrc    = c_alusrc_sext;
            ctrl.aluop     = c_aluop_add;
            ctrl.mem_write = 1'b1;
            ctrl.legal     = 1'b1;
        end else if (op_match(opcode, c_op_cbz, c_mask_cb)) begin
            ctrl.alusrc = c_alusrc_reg;
            ctrl.aluop  = c_aluop_pass;
            ctrl.bz     = 1'b1;
            ctrl.legal  = 1'b1;
        end else if (op_match(opcode, c_op_cbnz, c_mask_cb)) begin
            ctrl.alusrc = c_alusrc_reg;
            ctrl.aluop  = c_aluop_pass;
            ctrl.bnz    = 1'b1;
            ctrl.legal  = 1'b1;
        end else if (op_match(opcode, c_op_b, c_mask_b)) begin
            ctrl.aluop = c_aluop_pass;
            ctrl.b     = 1'b1;
            ctrl.legal = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/exec_sequencer.sv
// ============================================================================
// Module  : exec_sequencer
// Purpose : Multi-cycle IDLE/DECODE/EXEC/MEM/WB control sequencer for the
//           LEGv8 execute/memory datapath with a memory-wait timeout.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module exec_sequencer
    import legv8_pkg::*;
#(
    parameter int EXEC_LATENCY = 1,
    parameter int MEM_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        InstrValid,
    output logic        InstrReady,
    input  logic [31:0] Instruction,
    input  logic        MemReady,
    output logic [1:0]  ALUSrc,
    output logic [1:0]  ALUOp,
    output logic        B,
    output logic        BZ,
    output logic        BNZ,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        ExecEnable,
    output logic        PCWrite,
    output logic        Busy,
    output logic        IllegalOp,
    output logic        Timeout
);

    localparam int c_exec_w = $clog2(EXEC_LATENCY + 1);
    localparam int c_mem_w  = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_exec_w-1:0] c_exec_last = c_exec_w'(EXEC_LATENCY);
    localparam logic [c_mem_w-1:0]  c_mem_last  = c_mem_w'(MEM_TIMEOUT);

    logic [2:0]          r_state;
    logic [31:0]         r_instr;
    logic [c_exec_w-1:0] r_exec_cnt;
    logic [c_mem_w-1:0]  r_mem_cnt;
    logic [1:0]          r_alusrc, r_aluop;
    logic                r_b, r_bz, r_bnz, r_mem_read, r_mem_write, r_mem_to_reg;
    logic                r_reg_write, r_exec_en, r_pc_write, r_illegal, r_timeout;
    ctrl_t               w_ctrl;
    logic                w_unused_operands;

    // Decoding the latched word keeps Instruction off every control path
    legv8_decode u_decode (
        .opcode (r_instr[31:21]),
        .ctrl   (w_ctrl)
    );

    assign w_unused_operands = ^r_instr[20:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_instr      <= '0;
            r_exec_cnt   <= '0;
            r_mem_cnt    <= '0;
            r_alusrc     <= '0;
            r_aluop      <= '0;
            r_b          <= 1'b0;
            r_bz         <= 1'b0;
            r_bnz        <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_reg_write  <= 1'b0;
            r_exec_en    <= 1'b0;
            r_pc_write   <= 1'b0;
            r_illegal    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_reg_write <= 1'b0;
            r_exec_en   <= 1'b0;
            r_pc_write  <= 1'b0;
            r_illegal   <= 1'b0;
            r_timeout   <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (InstrValid) begin
                        r_instr <= Instruction;
                        r_state <= c_st_decode;
                    end
                end
                c_st_decode: begin
                    if (w_ctrl.legal) begin
                        r_alusrc     <= w_ctrl.alusrc;
                        r_aluop      <= w_ctrl.aluop;
                        r_b          <= w_ctrl.b;
                        r_bz         <= w_ctrl.bz;
                        r_bnz        <= w_ctrl.bnz;
                        r_mem_to_reg <= w_ctrl.mem_to_reg;
                        r_exec_en    <= 1'b1;
                        r_exec_cnt   <= c_exec_w'(1);
                        r_state      <= c_st_exec;
                    end else begin
                        r_illegal  <= 1'b1;
                        r_pc_write <= 1'b1;
                        r_state    <= c_st_idle;
                    end
                end
                c_st_exec: begin
                    if (r_exec_cnt == c_exec_last) begin
                        if (w_ctrl.mem_read || w_ctrl.mem_write) begin
                            r_mem_read  <= w_ctrl.mem_read;
                            r_mem_write <= w_ctrl.mem_write;
                            r_mem_cnt   <= c_mem_w'(1);
                            r_state     <= c_st_mem;
                        end else begin
                            r_reg_write <= w_ctrl.reg_write;
                            r_pc_write  <= 1'b1;
                            r_state     <= c_st_wb;
                        end
                    end else begin
                        r_exec_cnt <= r_exec_cnt + 1'b1;
                    end
                end
                c_st_mem: begin
                    if (MemReady) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_reg_write <= w_ctrl.reg_write;
                        r_pc_write  <= 1'b1;
                        r_state     <= c_st_wb;
                    end else if (r_mem_cnt == c_mem_last) begin
                        // Abort without retiring so fetch replays the access
                        r_alusrc     <= '0;
                        r_aluop      <= '0;
                        r_b          <= 1'b0;
                        r_bz         <= 1'b0;
                        r_bnz        <= 1'b0;
                        r_mem_read   <= 1'b0;
                        r_mem_write  <= 1'b0;
                        r_mem_to_reg <= 1'b0;
                        r_timeout    <= 1'b1;
                        r_state      <= c_st_idle;
                    end else begin
                        r_mem_cnt <= r_mem_cnt + 1'b1;
                    end
                end
                default: begin
                    r_alusrc     <= '0;
                    r_aluop      <= '0;
                    r_b          <= 1'b0;
                    r_bz         <= 1'b0;
                    r_bnz        <= 1'b0;
                    r_mem_read   <= 1'b0;
                    r_mem_write  <= 1'b0;
                    r_mem_to_reg <= 1'b0;
                    r_state      <= c_st_idle;
                end
            endcase
        end
    end

    assign InstrReady = (r_state == c_st_idle);
    assign Busy       = (r_state != c_st_idle);
    assign ALUSrc     = r_alusrc;
    assign ALUOp      = r_aluop;
    assign B          = r_b;
    assign BZ         = r_bz;
    assign BNZ        = r_bnz;
    assign MemRead    = r_mem_read;
    assign MemWrite   = r_mem_write;
    assign MemtoReg   = r_mem_to_reg;
    assign RegWrite   = r_reg_write;
    assign ExecEnable = r_exec_en;
    assign PCWrite    = r_pc_write;
    assign IllegalOp  = r_illegal;
    assign Timeout    = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_exec_sequencer.sv
// ============================================================================
// Module  : tb_exec_sequencer
// Purpose : Self-checking bench for exec_sequencer: directed vector table,
//           reset-abort sequence, and randomized instructions vs. a model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_exec_sequencer;

    localparam int L = 1;
    localparam int T = 16;

    // Observed vector: {ready,busy,alusrc[2],aluop[2],b,bz,bnz,rd,wr,m2r,rw,ee,pcw,ill,to}
    localparam logic [16:0] V_READY = 17'h10000;
    localparam logic [16:0] V_BUSY  = 17'h08000;
    localparam logic [16:0] V_RD    = 17'h00080;
    localparam logic [16:0] V_WR    = 17'h00040;
    localparam logic [16:0] V_RW    = 17'h00010;
    localparam logic [16:0] V_EE    = 17'h00008;
    localparam logic [16:0] V_PCW   = 17'h00004;
    localparam logic [16:0] V_ILL   = 17'h00002;
    localparam logic [16:0] V_TO    = 17'h00001;

    logic        clk = 1'b0;
    logic        reset;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instruction;
    logic        MemReady;
    logic [1:0]  ALUSrc, ALUOp;
    logic        B, BZ, BNZ, MemRead, MemWrite, MemtoReg, RegWrite;
    logic        ExecEnable, PCWrite, Busy, IllegalOp, Timeout;
    logic [16:0] obs;

    exec_sequencer #(.EXEC_LATENCY(L), .MEM_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .InstrValid(InstrValid), .InstrReady(InstrReady),
        .Instruction(Instruction), .MemReady(MemReady), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
        .B(B), .BZ(BZ), .BNZ(BNZ), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ExecEnable(ExecEnable),
        .PCWrite(PCWrite), .Busy(Busy), .IllegalOp(IllegalOp), .Timeout(Timeout)
    );

    always #5 clk = ~clk;

    assign obs = {InstrReady, Busy, ALUSrc, ALUOp, B, BZ, BNZ, MemRead, MemWrite,
                  MemtoReg, RegWrite, ExecEnable, PCWrite, IllegalOp, Timeout};

    typedef struct {
        logic       legal;
        logic [1:0] alusrc;
        logic [1:0] aluop;
        logic       b, bz, bnz, rd, wr, m2r, rw;
    } cls_t;

    typedef struct {
        logic [31:0] instr;
        int          d;
        cls_t        c;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic cls_t mkc(logic legal, logic [1:0] alusrc, logic [1:0] aluop,
                                 logic b, logic bz, logic bnz, logic rd, logic wr,
                                 logic m2r, logic rw);
        cls_t c;
        c.legal = legal; c.alusrc = alusrc; c.aluop = aluop;
        c.b = b; c.bz = bz; c.bnz = bnz; c.rd = rd; c.wr = wr; c.m2r = m2r; c.rw = rw;
        return c;
    endfunction

    function automatic vec_t mkv(logic [31:0] instr, int d, cls_t c);
        vec_t v;
        v.instr = instr; v.d = d; v.c = c;
        return v;
    endfunction

    // Reference classification straight from the opcode table
    function automatic cls_t model_cls(logic [31:0] w);
        logic [10:0] op;
        op = w[31:21];
        casez (op)
            11'b10001011000, 11'b11001011000,
            11'b10001010000, 11'b10101010000: return mkc(1, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 1);
            11'b1001000100?, 11'b1101000100?: return mkc(1, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 1);
            11'b11111000010:                  return mkc(1, 2'b01, 2'b00, 0, 0, 0, 1, 0, 1, 1);
            11'b11111000000:                  return mkc(1, 2'b01, 2'b00, 0, 0, 0, 0, 1, 0, 0);
            11'b10110100???:                  return mkc(1, 2'b00, 2'b01, 0, 1, 0, 0, 0, 0, 0);
            11'b10110101???:                  return mkc(1, 2'b00, 2'b01, 0, 0, 1, 0, 0, 0, 0);
            11'b000101?????:                  return mkc(1, 2'b00, 2'b01, 1, 0, 0, 0, 0, 0, 0);
            default:                          return mkc(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        endcase
    endfunction

    function automatic logic is_mem(cls_t c);
        return c.legal && (c.rd || c.wr);
    endfunction

    // Memory wait cycles spent in MEM; d is the MEM cycle on which MemReady rises
    function automatic int mem_cycles(cls_t c, int d);
        if (!is_mem(c)) return 0;
        return (d <= T) ? d : T;
    endfunction

    function automatic logic timed_out(cls_t c, int d);
        return is_mem(c) && (d > T);
    endfunction

    // Cycle index (accept cycle = 0) at which the sequencer is back in IDLE
    function automatic int last_cycle(cls_t c, int d);
        if (!c.legal) return 2;
        if (timed_out(c, d)) return 2 + L + mem_cycles(c, d);
        return 3 + L + mem_cycles(c, d);
    endfunction

    function automatic logic [16:0] expect_at(cls_t c, int d, int k);
        int          wb;
        logic [16:0] held;
        wb   = 2 + L + mem_cycles(c, d);
        held = {1'b0, 1'b1, c.alusrc, c.aluop, c.b, c.bz, c.bnz, 1'b0, 1'b0, c.m2r, 5'b0};
        if (k == 0) return V_READY;
        if (k == 1) return V_BUSY;
        if (!c.legal) return V_READY | V_PCW | V_ILL;
        if (k <= 1 + L) return held | ((k == 2) ? V_EE : 17'h0);
        if (k < wb) return held | (c.rd ? V_RD : 17'h0) | (c.wr ? V_WR : 17'h0);
        if (timed_out(c, d)) return V_READY | V_TO;
        if (k == wb) return held | (c.rw ? V_RW : 17'h0) | V_PCW;
        return V_READY;
    endfunction

    task automatic check(input string name, input logic [16:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %05h expected %05h", name, obs, exp);
    endtask

    task automatic run_txn(input logic [31:0] instr, input int d, input cls_t c, input string tag);
        int last;
        int mstart;
        last   = last_cycle(c, d);
        mstart = 2 + L;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            check($sformatf("%s instr=%08h d=%0d cyc=%0d", tag, instr, d, k), expect_at(c, d, k));
            if (k == 0) begin
                InstrValid  = 1'b1;
                Instruction = instr;
            end else if (k < last) begin
                InstrValid  = 1'($urandom_range(0, 1));
                Instruction = $urandom;
            end else begin
                InstrValid  = 1'b0;
            end
            if (is_mem(c) && k >= mstart && k < mstart + mem_cycles(c, d))
                MemReady = (k - mstart + 1 == d);
            else
                MemReady = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        vec_t        tbl[$];
        logic [10:0] pats[11];
        logic [10:0] dcs[11];
        logic [31:0] w;
        int          r;
        int          d;
        cls_t        ld;

        pats = '{11'h458, 11'h658, 11'h450, 11'h550, 11'h488, 11'h688,
                 11'h7C2, 11'h7C0, 11'h5A0, 11'h5A8, 11'h0A0};
        dcs  = '{11'h000, 11'h000, 11'h000, 11'h000, 11'h001, 11'h001,
                 11'h000, 11'h000, 11'h007, 11'h007, 11'h01F};

        reset = 1'b1; InstrValid = 1'b0; Instruction = '0; MemReady = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", V_READY);
        reset = 1'b0;

        // legal, alusrc, aluop, b, bz, bnz, rd, wr, m2r, rw
        tbl.push_back(mkv(32'h8B020020, 0,  mkc(1, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 1)));
        tbl.push_back(mkv(32'hCB020020, 0,  mkc(1, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 1)));
        tbl.push_back(mkv(32'h8A020020, 0,  mkc(1, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 1)));
        tbl.push_back(mkv(32'hAA020020, 0,  mkc(1, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 1)));
        tbl.push_back(mkv(32'h91200420, 0,  mkc(1, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 1)));
        tbl.push_back(mkv(32'hD1000420, 0,  mkc(1, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 1)));
        tbl.push_back(mkv(32'hF8408020, 4,  mkc(1, 2'b01, 2'b00, 0, 0, 0, 1, 0, 1, 1)));
        tbl.push_back(mkv(32'hF8408020, 1,  mkc(1, 2'b01, 2'b00, 0, 0, 0, 1, 0, 1, 1)));
        tbl.push_back(mkv(32'hF8408020, 16, mkc(1, 2'b01, 2'b00, 0, 0, 0, 1, 0, 1, 1)));
        tbl.push_back(mkv(32'hF8000020, 99, mkc(1, 2'b01, 2'b00, 0, 0, 0, 0, 1, 0, 0)));
        tbl.push_back(mkv(32'hF8000020, 2,  mkc(1, 2'b01, 2'b00, 0, 0, 0, 0, 1, 0, 0)));
        tbl.push_back(mkv(32'hB4000040, 0,  mkc(1, 2'b00, 2'b01, 0, 1, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv(32'hB5000040, 0,  mkc(1, 2'b00, 2'b01, 0, 0, 1, 0, 0, 0, 0)));
        tbl.push_back(mkv(32'h14000010, 0,  mkc(1, 2'b00, 2'b01, 1, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv(32'h00000000, 0,  mkc(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv(32'hF8600000, 0,  mkc(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0)));

        foreach (tbl[i]) run_txn(tbl[i].instr, tbl[i].d, tbl[i].c, $sformatf("vec%0d", i));

        // Reset while waiting in MEM must abort cleanly with no retirement pulses
        ld = mkc(1, 2'b01, 2'b00, 0, 0, 0, 1, 0, 1, 1);
        @(negedge clk);
        check("rst_mem accept", V_READY);
        InstrValid = 1'b1; Instruction = 32'hF8408020; MemReady = 1'b0;
        @(negedge clk);
        check("rst_mem decode", expect_at(ld, 99, 1));
        InstrValid = 1'b0;
        @(negedge clk);
        check("rst_mem exec", expect_at(ld, 99, 2));
        @(negedge clk);
        check("rst_mem mem", expect_at(ld, 99, 3));
        reset = 1'b1;
        @(negedge clk);
        check("rst_mem after reset", V_READY);
        reset = 1'b0; MemReady = 1'b1;
        @(negedge clk);
        check("rst_mem quiet1", V_READY);
        MemReady = 1'b0;
        @(negedge clk);
        check("rst_mem quiet2", V_READY);

        for (int i = 0; i < 200; i++) begin
            w = $urandom;
            r = $urandom_range(0, 13);
            if (r < 11) w[31:21] = pats[r] | (w[31:21] & dcs[r]);
            d = $urandom_range(1, 20);
            run_txn(w, d, model_cls(w), $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
